// File: rtl/sh7604_frt_intc_pkg.sv
// -----------------------------------------------------------------------------
// SH7604_PKG -- shared types and constants for the SH7604 FRT interrupt
// controller slice (IPRB FRT priority field, VCRC/VCRD vector registers).
//
// Contents:
//   * register addresses (IPRB, VCRC, VCRD, optional status halfword)
//   * IPRB_t / VCRC_t / VCRD_t register layouts with INIT/WMASK/RMASK
//   * frt_state_e request state machine encoding
//   * hw_merge(): byte-enable aware halfword write helper
// -----------------------------------------------------------------------------
package SH7604_PKG;

  localparam logic [31:0] FRT_BASE_ADDR = 32'hFFFF_FE60;
  localparam logic [31:0] FRT_IPRB_ADDR = FRT_BASE_ADDR;
  localparam logic [31:0] FRT_VCRC_ADDR = FRT_BASE_ADDR + 32'd6;
  localparam logic [31:0] FRT_VCRD_ADDR = FRT_BASE_ADDR + 32'd8;
  localparam logic [31:0] FRT_STAT_ADDR = FRT_BASE_ADDR + 32'd10;

  // IPRB: only the FRT priority level [11:8] is implemented here.
  typedef struct packed {
    logic [3:0] rsv_15_12;
    logic [3:0] frt;
    logic [7:0] rsv_7_0;
  } IPRB_t;

  // VCRC: input-capture vector [14:8], output-compare vector [6:0].
  typedef struct packed {
    logic       rsv_15;
    logic [6:0] ficv;
    logic       rsv_7;
    logic [6:0] focv;
  } VCRC_t;

  // VCRD: overflow vector [14:8].
  typedef struct packed {
    logic       rsv_15;
    logic [6:0] fovv;
    logic [7:0] rsv_7_0;
  } VCRD_t;

  localparam IPRB_t       IPRB_INIT  = '0;
  localparam logic [15:0] IPRB_WMASK = 16'h0F00;
  localparam logic [15:0] IPRB_RMASK = 16'h0F00;

  localparam VCRC_t       VCRC_INIT  = '0;
  localparam logic [15:0] VCRC_WMASK = 16'h7F7F;
  localparam logic [15:0] VCRC_RMASK = 16'h7F7F;

  localparam VCRD_t       VCRD_INIT  = '0;
  localparam logic [15:0] VCRD_WMASK = 16'h7F00;
  localparam logic [15:0] VCRD_RMASK = 16'h7F00;

  // Encoding is visible through the optional status register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } frt_state_e;

  // be[1] enables the high byte [15:8], be[0] the low byte [7:0].
  // Unimplemented bits are forced to 0 so they always read back as 0.
  function automatic logic [15:0] hw_merge(input logic [15:0] old_v,
                                           input logic [15:0] wdata,
                                           input logic [1:0]  be,
                                           input logic [15:0] wmask);
    logic [15:0] merged;
    merged = old_v;
    if (be[1]) merged[15:8] = wdata[15:8];
    if (be[0]) merged[7:0]  = wdata[7:0];
    return merged & wmask;
  endfunction

endpackage

// File: rtl/sh7604_frt_intc_prio.sv
// -----------------------------------------------------------------------------
// sh7604_frt_intc_prio -- combinational FRT source selection.
//
// Fixed priority ICI > OCI (OCIA or OCIB, sharing FOCV) > OVI.
//
// Ports:
//   req_i   [3:0]  raw requests {ICI, OCIA, OCIB, OVI}
//   ficv_i  [6:0]  VCRC input-capture vector field
//   focv_i  [6:0]  VCRC output-compare vector field
//   fovv_i  [6:0]  VCRD overflow vector field
//   any_o          at least one request is high
//   vec_o   [6:0]  vector of the highest-priority active request (0 if none)
// -----------------------------------------------------------------------------
module sh7604_frt_intc_prio (
  input  logic [3:0] req_i,
  input  logic [6:0] ficv_i,
  input  logic [6:0] focv_i,
  input  logic [6:0] fovv_i,
  output logic       any_o,
  output logic [6:0] vec_o
);

  assign any_o = |req_i;

  // NOTE: give every combinational output a default before the branches so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    vec_o = 7'd0;
    if (req_i[3])                 vec_o = ficv_i;
    else if (req_i[2] | req_i[1]) vec_o = focv_i;
    else if (req_i[0])            vec_o = fovv_i;
  end

endmodule

// File: rtl/sh7604_frt_intc.sv
// -----------------------------------------------------------------------------
// sh7604_frt_intc -- SH7604 free-running-timer interrupt controller slice.
//
// Holds the IPRB FRT priority field and the VCRC/VCRD vector registers,
// selects the highest-priority FRT request and drives a level-sensitive
// IDLE -> REQ -> ACK request handshake towards the CPU.
//
// Bus layout: 32-bit big-endian internal bus. A register is selected by its
// halfword address (ibus_a_i with bit 0 ignored); ibus_a_i[1]=0 places the
// halfword on lanes [31:16] / ibus_ba_i[3:2], ibus_a_i[1]=1 on lanes [15:0] /
// ibus_ba_i[1:0]. Writes land on ce_r_i, read data is registered on ce_f_i.
//
// Optional build macro: SH7604_FRT_INTC_STAT_EN adds a read-only status
// halfword at BASE+10: [3:0] = {ICI,OCIA,OCIB,OVI}, [5:4] = state.
//
// Ports:
//   clk_i, rst_n_i        clock, async active-low reset
//   ce_r_i, ce_f_i        rise / fall clock enables
//   res_n_i               sync active-low soft reset (sampled on ce_r_i)
//   ici/ocia/ocib/ovi_irq_i  level requests from the FRT
//   ibus_a_i/di_i/ba_i/we_i/req_i  register bus in
//   ibus_do_o, ibus_busy_o (0), ibus_act_o  register bus out
//   int_req_o, int_lvl_o, int_vec_o  request to the CPU
//   int_ack_i             CPU acceptance strobe (sampled on ce_r_i)
// -----------------------------------------------------------------------------
module sh7604_frt_intc
  import SH7604_PKG::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ce_r_i,
  input  logic        ce_f_i,
  input  logic        res_n_i,
  input  logic        ici_irq_i,
  input  logic        ocia_irq_i,
  input  logic        ocib_irq_i,
  input  logic        ovi_irq_i,
  input  logic [31:0] ibus_a_i,
  input  logic [31:0] ibus_di_i,
  output logic [31:0] ibus_do_o,
  input  logic [3:0]  ibus_ba_i,
  input  logic        ibus_we_i,
  input  logic        ibus_req_i,
  output logic        ibus_busy_o,
  output logic        ibus_act_o,
  output logic        int_req_o,
  output logic [3:0]  int_lvl_o,
  output logic [6:0]  int_vec_o,
  input  logic        int_ack_i
);

  IPRB_t       iprb_q;
  VCRC_t       vcrc_q;
  VCRD_t       vcrd_q;
  frt_state_e  state_q;
  logic        int_req_q;
  logic [3:0]  int_lvl_q;
  logic [6:0]  int_vec_q;
  logic [31:0] ibus_do_q;

  // ---------------------------------------------------------------------------
  // Source selection
  // ---------------------------------------------------------------------------
  logic [3:0] src_raw;
  logic       src_any;
  logic [6:0] src_vec;
  logic       lvl_zero;

  assign src_raw  = {ici_irq_i, ocia_irq_i, ocib_irq_i, ovi_irq_i};
  assign lvl_zero = (iprb_q.frt == 4'd0);

  sh7604_frt_intc_prio u_prio (
    .req_i  (src_raw),
    .ficv_i (vcrc_q.ficv),
    .focv_i (vcrc_q.focv),
    .fovv_i (vcrd_q.fovv),
    .any_o  (src_any),
    .vec_o  (src_vec)
  );

  // ---------------------------------------------------------------------------
  // Address decode and lane steering
  // ---------------------------------------------------------------------------
  logic [31:0] hw_addr;
  logic        sel_iprb;
  logic        sel_vcrc;
  logic        sel_vcrd;
  logic        sel_stat;
  logic        sel_any;
  logic [15:0] stat_hw;
  logic [15:0] wr_hw;
  logic [1:0]  wr_be;
  logic [15:0] rd_hw;
  logic [31:0] rd_word;
  logic        wr_en;

  assign hw_addr  = ibus_a_i & 32'hFFFF_FFFE;
  assign sel_iprb = (hw_addr == FRT_IPRB_ADDR);
  assign sel_vcrc = (hw_addr == FRT_VCRC_ADDR);
  assign sel_vcrd = (hw_addr == FRT_VCRD_ADDR);

`ifdef SH7604_FRT_INTC_STAT_EN
  assign sel_stat = (hw_addr == FRT_STAT_ADDR);
  assign stat_hw  = {10'd0, state_q, src_raw};
`else
  assign sel_stat = 1'b0;
  assign stat_hw  = 16'h0000;
`endif

  assign sel_any  = sel_iprb | sel_vcrc | sel_vcrd | sel_stat;
  assign wr_hw    = ibus_a_i[1] ? ibus_di_i[15:0] : ibus_di_i[31:16];
  assign wr_be    = ibus_a_i[1] ? ibus_ba_i[1:0]  : ibus_ba_i[3:2];
  assign wr_en    = ibus_req_i & ibus_we_i;

  always_comb begin
    rd_hw = 16'h0000;
    if (sel_iprb)      rd_hw = iprb_q & IPRB_RMASK;
    else if (sel_vcrc) rd_hw = vcrc_q & VCRC_RMASK;
    else if (sel_vcrd) rd_hw = vcrd_q & VCRD_RMASK;
    else if (sel_stat) rd_hw = stat_hw;
  end

  assign rd_word = ibus_a_i[1] ? {16'h0000, rd_hw} : {rd_hw, 16'h0000};

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here is a flop with a defined reset value; nothing is
  // left uninitialised, so both the async and the soft reset clear it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      iprb_q <= IPRB_INIT;
      vcrc_q <= VCRC_INIT;
      vcrd_q <= VCRD_INIT;
    end else if (ce_r_i) begin
      if (!res_n_i) begin
        iprb_q <= IPRB_INIT;
        vcrc_q <= VCRC_INIT;
        vcrd_q <= VCRD_INIT;
      end else if (wr_en) begin
        if (sel_iprb) iprb_q <= IPRB_t'(hw_merge(iprb_q, wr_hw, wr_be, IPRB_WMASK));
        if (sel_vcrc) vcrc_q <= VCRC_t'(hw_merge(vcrc_q, wr_hw, wr_be, VCRC_WMASK));
        if (sel_vcrd) vcrd_q <= VCRD_t'(hw_merge(vcrd_q, wr_hw, wr_be, VCRD_WMASK));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request state machine
  // ---------------------------------------------------------------------------
  // All decisions use the register values from before this edge, so a write
  // landing together with INT_ACK cannot alter the acknowledged vector; it is
  // picked up by the next request. A withdrawn request (no source or level 0)
  // takes precedence over an acknowledge arriving on the same edge.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      int_req_q <= 1'b0;
      int_lvl_q <= 4'd0;
      int_vec_q <= 7'd0;
    end else if (ce_r_i) begin
      if (!res_n_i) begin
        state_q   <= ST_IDLE;
        int_req_q <= 1'b0;
        int_lvl_q <= 4'd0;
        int_vec_q <= 7'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (src_any && !lvl_zero) begin
              state_q   <= ST_REQ;
              int_req_q <= 1'b1;
              int_lvl_q <= iprb_q.frt;
              int_vec_q <= src_vec;
            end
          end
          ST_REQ: begin
            if (!src_any || lvl_zero) begin
              state_q   <= ST_IDLE;
              int_req_q <= 1'b0;
            end else if (int_ack_i) begin
              // Vector and level stay frozen for the acknowledge.
              state_q   <= ST_ACK;
              int_req_q <= 1'b0;
            end else begin
              int_lvl_q <= iprb_q.frt;
              int_vec_q <= src_vec;
            end
          end
          ST_ACK: begin
            state_q   <= ST_IDLE;
            int_req_q <= 1'b0;
          end
          default: begin
            state_q   <= ST_IDLE;
            int_req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ibus_do_q <= 32'h0;
    end else if (ce_r_i && !res_n_i) begin
      ibus_do_q <= 32'h0;
    end else if (ce_f_i) begin
      ibus_do_q <= (ibus_req_i && !ibus_we_i) ? rd_word : 32'h0;
    end
  end

  assign ibus_do_o   = ibus_do_q;
  assign ibus_busy_o = 1'b0;
  assign ibus_act_o  = sel_any;
  assign int_req_o   = int_req_q;
  assign int_lvl_o   = int_lvl_q;
  assign int_vec_o   = int_vec_q;

endmodule

// File: tb/tb_sh7604_frt_intc.sv
// -----------------------------------------------------------------------------
// tb_sh7604_frt_intc -- self-checking bench for sh7604_frt_intc.
//
// A behavioural model (request/acknowledge flags, priority picked with plain
// if/else on the raw sources, registers as masked halfwords) is compared with
// the DUT on every falling clock edge. Directed sequences pin the model with
// literal expectations; a randomized phase then exercises bus traffic,
// sources, acknowledges and soft resets.
// -----------------------------------------------------------------------------
module tb_sh7604_frt_intc;

  localparam logic [31:0] A_IPRB = 32'hFFFF_FE60;
  localparam logic [31:0] A_VCRC = 32'hFFFF_FE66;
  localparam logic [31:0] A_VCRD = 32'hFFFF_FE68;
  localparam logic [31:0] A_STAT = 32'hFFFF_FE6A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce_r = 1'b0;
  logic        ce_f = 1'b0;
  logic        res_n = 1'b1;
  logic        ici = 1'b0, ocia = 1'b0, ocib = 1'b0, ovi = 1'b0;
  logic [31:0] ibus_a = 32'h0;
  logic [31:0] ibus_di = 32'h0;
  logic [31:0] ibus_do;
  logic [3:0]  ibus_ba = 4'h0;
  logic        ibus_we = 1'b0;
  logic        ibus_req = 1'b0;
  logic        ibus_busy, ibus_act;
  logic        int_req;
  logic [3:0]  int_lvl;
  logic [6:0]  int_vec;
  logic        int_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sh7604_frt_intc dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .ce_r_i     (ce_r),
    .ce_f_i     (ce_f),
    .res_n_i    (res_n),
    .ici_irq_i  (ici),
    .ocia_irq_i (ocia),
    .ocib_irq_i (ocib),
    .ovi_irq_i  (ovi),
    .ibus_a_i   (ibus_a),
    .ibus_di_i  (ibus_di),
    .ibus_do_o  (ibus_do),
    .ibus_ba_i  (ibus_ba),
    .ibus_we_i  (ibus_we),
    .ibus_req_i (ibus_req),
    .ibus_busy_o(ibus_busy),
    .ibus_act_o (ibus_act),
    .int_req_o  (int_req),
    .int_lvl_o  (int_lvl),
    .int_vec_o  (int_vec),
    .int_ack_i  (int_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [15:0] m_iprb = 16'h0, m_vcrc = 16'h0, m_vcrd = 16'h0;
  bit          m_pending = 0;   // request is being presented to the CPU
  bit          m_acking  = 0;   // the single CE_R after an accepted request
  logic [3:0]  m_lvl = 4'h0;
  logic [6:0]  m_vec = 7'h0;
  logic [31:0] m_do  = 32'h0;

  function automatic bit addr_is(input logic [31:0] a, input logic [31:0] reg_a);
    return {a[31:1], 1'b0} == reg_a;
  endfunction

  function automatic bit model_act(input logic [31:0] a);
    bit s;
    s = addr_is(a, A_IPRB) || addr_is(a, A_VCRC) || addr_is(a, A_VCRD);
`ifdef SH7604_FRT_INTC_STAT_EN
    s = s || addr_is(a, A_STAT);
`endif
    return s;
  endfunction

  function automatic logic [15:0] model_read(input logic [31:0] a);
    logic [1:0] code;
    code = m_pending ? 2'd1 : (m_acking ? 2'd2 : 2'd0);
    if (addr_is(a, A_IPRB)) return m_iprb;
    if (addr_is(a, A_VCRC)) return m_vcrc;
    if (addr_is(a, A_VCRD)) return m_vcrd;
`ifdef SH7604_FRT_INTC_STAT_EN
    if (addr_is(a, A_STAT)) return {10'd0, code, ici, ocia, ocib, ovi};
`endif
    return (code == 2'd3) ? 16'hFFFF : 16'h0000;
  endfunction

  function automatic logic [15:0] model_write(input logic [15:0] old_v, input logic [31:0] a,
                                              input logic [31:0] d, input logic [3:0] ba,
                                              input logic [15:0] keep);
    logic [15:0] v;
    logic [1:0]  en;
    logic [15:0] nd;
    v  = old_v;
    nd = a[1] ? d[15:0] : d[31:16];
    en = a[1] ? ba[1:0] : ba[3:2];
    if (en[1]) v[15:8] = nd[15:8];
    if (en[0]) v[7:0]  = nd[7:0];
    return v & keep;
  endfunction

  task automatic model_clear();
    m_iprb = 16'h0; m_vcrc = 16'h0; m_vcrd = 16'h0;
    m_pending = 0; m_acking = 0;
    m_lvl = 4'h0; m_vec = 7'h0; m_do = 32'h0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [6:0] vec_now;
    logic [3:0] lvl_now;
    bit         any_now;
    logic [15:0] hw;
    if (!rst_n) begin
      model_clear();
    end else if (ce_r) begin
      if (!res_n) begin
        model_clear();
      end else begin
        any_now = ici || ocia || ocib || ovi;
        lvl_now = m_iprb[11:8];
        if (ici)              vec_now = m_vcrc[14:8];
        else if (ocia || ocib) vec_now = m_vcrc[6:0];
        else if (ovi)         vec_now = m_vcrd[14:8];
        else                  vec_now = 7'h0;
        if (m_acking) begin
          m_acking = 0;
        end else if (m_pending) begin
          if (!any_now || lvl_now == 0) m_pending = 0;
          else if (int_ack) begin m_pending = 0; m_acking = 1; end
          else begin m_lvl = lvl_now; m_vec = vec_now; end
        end else if (any_now && lvl_now != 0) begin
          m_pending = 1; m_lvl = lvl_now; m_vec = vec_now;
        end
        if (ibus_req && ibus_we) begin
          if (addr_is(ibus_a, A_IPRB)) m_iprb = model_write(m_iprb, ibus_a, ibus_di, ibus_ba, 16'h0F00);
          if (addr_is(ibus_a, A_VCRC)) m_vcrc = model_write(m_vcrc, ibus_a, ibus_di, ibus_ba, 16'h7F7F);
          if (addr_is(ibus_a, A_VCRD)) m_vcrd = model_write(m_vcrd, ibus_a, ibus_di, ibus_ba, 16'h7F00);
        end
      end
    end else if (ce_f) begin
      hw   = (ibus_req && !ibus_we) ? model_read(ibus_a) : 16'h0;
      m_do = ibus_a[1] ? {16'h0, hw} : {hw, 16'h0};
    end
  end

  // One compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    check("int_req",   {31'b0, int_req},   {31'b0, m_pending});
    check("int_lvl",   {28'b0, int_lvl},   {28'b0, m_lvl});
    check("int_vec",   {25'b0, int_vec},   {25'b0, m_vec});
    check("ibus_do",   ibus_do,            m_do);
    check("ibus_act",  {31'b0, ibus_act},  {31'b0, model_act(ibus_a)});
    check("ibus_busy", {31'b0, ibus_busy}, 32'h0);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: one call = one CE_R cycle followed by one CE_F cycle
  // ---------------------------------------------------------------------------
  task automatic tick();
    ce_r = 1'b1; ce_f = 1'b0;
    @(negedge clk); #1;
    ce_r = 1'b0; ce_f = 1'b1;
    @(negedge clk); #1;
    ce_f = 1'b0;
  endtask

  task automatic wr16(input logic [31:0] a, input logic [15:0] d);
    ibus_req = 1'b1; ibus_we = 1'b1; ibus_a = a;
    ibus_di  = a[1] ? {16'h0, d} : {d, 16'h0};
    ibus_ba  = a[1] ? 4'b0011 : 4'b1100;
    tick();
    ibus_req = 1'b0; ibus_we = 1'b0; ibus_ba = 4'h0;
  endtask

  task automatic rd16(input logic [31:0] a, output logic [15:0] v);
    ibus_req = 1'b1; ibus_we = 1'b0; ibus_a = a;
    tick();
    v = a[1] ? ibus_do[15:0] : ibus_do[31:16];
    ibus_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int          stuck;
    logic [31:0] addrs [8];
    addrs[0] = A_IPRB; addrs[1] = A_VCRC; addrs[2] = A_VCRD; addrs[3] = A_STAT;
    addrs[4] = 32'hFFFF_FE62; addrs[5] = 32'hFFFF_FE64; addrs[6] = 32'hFFFF_FE61;
    addrs[7] = 32'h1234_5678;

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("reset_req", {31'b0, int_req}, 32'h0);
    check("reset_lvl", {28'b0, int_lvl}, 32'h0);
    check("reset_vec", {25'b0, int_vec}, 32'h0);
    check("reset_do",  ibus_do, 32'h0);

    // Basic OCIB request and register read-back / masking.
    wr16(A_IPRB, 16'h0500);
    wr16(A_VCRC, 16'h0040);
    rd16(A_IPRB, v); check("iprb_rd", {16'h0, v}, 32'h0500);
    rd16(A_VCRC, v); check("vcrc_rd", {16'h0, v}, 32'h0040);
    wr16(A_VCRD, 16'hFFFF);
    rd16(A_VCRD, v); check("vcrd_mask", {16'h0, v}, 32'h7F00);
    ocib = 1'b1; tick();
    check("ocib_req", {31'b0, int_req}, 32'h1);
    check("ocib_lvl", {28'b0, int_lvl}, 32'h5);
    check("ocib_vec", {25'b0, int_vec}, 32'h40);
    ocib = 1'b0; tick();
    check("ocib_drop", {31'b0, int_req}, 32'h0);

    // Priority re-evaluation in REQ, then acknowledge and re-request.
    wr16(A_VCRC, 16'h4140);
    wr16(A_VCRD, 16'h4300);
    ovi = 1'b1; tick();
    check("ovi_vec", {25'b0, int_vec}, 32'h43);
    ici = 1'b1; tick();
    check("ici_vec", {25'b0, int_vec}, 32'h41);
    check("ici_req", {31'b0, int_req}, 32'h1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("ack_req", {31'b0, int_req}, 32'h0);
    check("ack_vec", {25'b0, int_vec}, 32'h41);
    tick();
    check("ack_to_idle", {31'b0, int_req}, 32'h0);
    tick();
    check("rerequest", {31'b0, int_req}, 32'h1);
    ici = 1'b0; ovi = 1'b0; tick();
    check("all_low", {31'b0, int_req}, 32'h0);

    // Sources withdrawn before the acknowledge; the late ack is ignored.
    ocia = 1'b1; tick();
    check("ocia_req", {31'b0, int_req}, 32'h1);
    ocia = 1'b0; tick();
    check("withdraw", {31'b0, int_req}, 32'h0);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("late_ack", {31'b0, int_req}, 32'h0);

    // Register write coinciding with INT_ACK.
    wr16(A_IPRB, 16'h0300);
    wr16(A_VCRC, 16'h0040);
    ocia = 1'b1; tick();
    check("coin_pre", {25'b0, int_vec}, 32'h40);
    int_ack = 1'b1; ibus_req = 1'b1; ibus_we = 1'b1; ibus_a = A_VCRC;
    ibus_di = 32'h0000_0022; ibus_ba = 4'b0011;
    tick();
    int_ack = 1'b0; ibus_req = 1'b0; ibus_we = 1'b0; ibus_ba = 4'h0;
    check("coin_ack_vec", {25'b0, int_vec}, 32'h40);
    check("coin_ack_lvl", {28'b0, int_lvl}, 32'h3);
    tick(); tick();
    check("coin_new_vec", {25'b0, int_vec}, 32'h22);
    ocia = 1'b0; tick();

    // Level 0 blocks every request.
    wr16(A_IPRB, 16'h0000);
    ici = 1'b1; ocia = 1'b1; ocib = 1'b1; ovi = 1'b1;
    stuck = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (int_req !== 1'b0) stuck++;
    end
    check("lvl0_quiet", stuck, 0);
    ici = 1'b0; ocia = 1'b0; ocib = 1'b0; ovi = 1'b0; tick();

    // Async reset while in ACK; then a single byte write.
    wr16(A_IPRB, 16'h0500);
    ocib = 1'b1; tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    rst_n = 1'b0; #1;
    check("rst_in_ack_req", {31'b0, int_req}, 32'h0);
    ocib = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    rd16(A_IPRB, v); check("rst_iprb", {16'h0, v}, 32'h0);
    rd16(A_VCRC, v); check("rst_vcrc", {16'h0, v}, 32'h0);
    rd16(A_VCRD, v); check("rst_vcrd", {16'h0, v}, 32'h0);
    ibus_req = 1'b1; ibus_we = 1'b1; ibus_a = A_IPRB; ibus_di = 32'h0A00_0000; ibus_ba = 4'b1000;
    tick();
    ibus_req = 1'b0; ibus_we = 1'b0; ibus_ba = 4'h0;
    rd16(A_IPRB, v); check("byte_wr_iprb", {16'h0, v}, 32'h0A00);
    rd16(32'hFFFF_FE62, v); check("unsel_rd", {16'h0, v}, 32'h0);

`ifdef SH7604_FRT_INTC_STAT_EN
    ocia = 1'b1; tick();
    rd16(A_STAT, v); check("stat_req", {16'h0, v}, 32'h0014);
    ocia = 1'b0; tick();
`else
    rd16(A_STAT, v); check("stat_absent", {16'h0, v}, 32'h0);
`endif

    // Soft reset clears the registers.
    res_n = 1'b0; tick(); res_n = 1'b1;
    rd16(A_IPRB, v); check("soft_rst_iprb", {16'h0, v}, 32'h0);
    wr16(A_IPRB, 16'h0700);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int t = 0; t < 2500; t++) begin
      if ($urandom_range(0, 9) == 0) ici  = ~ici;
      if ($urandom_range(0, 9) == 0) ocia = ~ocia;
      if ($urandom_range(0, 9) == 0) ocib = ~ocib;
      if ($urandom_range(0, 9) == 0) ovi  = ~ovi;
      int_ack = ($urandom_range(0, 3) == 0);
      res_n   = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) == 0) begin
        ibus_req = 1'b1;
        ibus_we  = $urandom_range(0, 1);
        ibus_a   = addrs[$urandom_range(0, 7)];
        ibus_di  = $urandom;
        ibus_ba  = 4'($urandom_range(0, 15));
      end else begin
        ibus_req = 1'b0; ibus_we = 1'b0;
      end
      tick();
    end
    int_ack = 1'b0; ibus_req = 1'b0; ibus_we = 1'b0; res_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sh7604_frt_intc.md
SH7604_FRT_INTC -- requirements
Module: sh7604_frt_intc

Interface
- REQ-001 BASE_ADDR, 32'hFFFFFE60, SHALL be the byte address of the IPRB register; VCRC is at BASE_ADDR+6 and VCRD at BASE_ADDR+8.
- REQ-002 CLK in 1: system clock; the block SHALL use one clock only.
- REQ-003 RST_N in 1: reset, SHALL be asynchronous and active-low.
- REQ-004 CE_R / CE_F in 1 each: rise/fall clock enables; state and register writes SHALL update on CE_R, read data on CE_F.
- REQ-005 RES_N in 1: synchronous soft reset, active-low.
- REQ-006 ICI_IRQ, OCIA_IRQ, OCIB_IRQ, OVI_IRQ in 1 each: level requests from the free-running timer.
- REQ-007 IBUS_A in 32, IBUS_DI in 32, IBUS_DO out 32, IBUS_BA in 4, IBUS_WE in 1, IBUS_REQ in 1: internal register bus.
- REQ-008 IBUS_BUSY out 1 (constant 0) and IBUS_ACT out 1 (high while the address selects a register of this block).
- REQ-009 INT_REQ out 1: interrupt request to the CPU.
- REQ-010 INT_LVL out 4: priority level of the request.
- REQ-011 INT_VEC out 7: vector number of the request.
- REQ-012 INT_ACK in 1: CPU acceptance strobe, sampled on CE_R.

Function
- REQ-013 Registers: IPRB FRT field [11:8] R/W; VCRC FICV [14:8] and FOCV [6:0] R/W; VCRD FOVV [14:8] R/W; all other bits SHALL read 0 and ignore writes; byte/word writes SHALL honour IBUS_BA.
- REQ-014 Fixed source priority SHALL be ICI > OCI (OCIA or OCIB) > OVI; OCIA and OCIB SHALL share FOCV.
- REQ-015 State machine IDLE/REQ/ACK; IDLE SHALL move to REQ on the first CE_R on which any source is high and the level is not 0.
- REQ-016 INT_REQ SHALL assert on the CE_R after the source is sampled, giving 1 CE_R of latency.
- REQ-017 In REQ, INT_VEC SHALL be re-evaluated every CE_R from the highest-priority active source, and INT_LVL SHALL follow IPRB.
- REQ-018 In REQ, if all sources go low, or the level is written to 0, before INT_ACK, the block SHALL return to IDLE and deassert INT_REQ on the same CE_R.
- REQ-019 REQ SHALL move to ACK on INT_ACK, freezing INT_VEC/INT_LVL; INT_REQ SHALL be low in ACK.
- REQ-020 ACK SHALL last exactly one CE_R and then go to IDLE; a source still high SHALL re-request from IDLE (level-sensitive, no edge latch).
- REQ-021 INT_ACK outside REQ SHALL be ignored.
- REQ-022 A register write coinciding with INT_ACK: the ACK SHALL use the pre-write vector, and the new value SHALL apply from the next request.
- REQ-023 IBUS_DO SHALL be 0 when the address is unselected.

Reset
- REQ-024 On RST_N low, or on RES_N low at CE_R: state IDLE; INT_REQ=0, INT_LVL=0, INT_VEC=0, IBUS_DO=0; IPRB, VCRC and VCRD cleared to 0.
- REQ-025 Reset in REQ or ACK SHALL drop INT_REQ at once, and no acknowledge SHALL be generated.

Configuration
- REQ-026 SH7604_FRT_INTC_STAT_EN defined: a read-only status halfword at BASE_ADDR+10 SHALL hold [3:0] = raw {ICI,OCIA,OCIB,OVI} and [5:4] = state encoding (IDLE=0, REQ=1, ACK=2).
- REQ-027 SH7604_FRT_INTC_STAT_EN undefined: that address SHALL be unselected, with IBUS_ACT=0 and a read value of 0.

Structure
- REQ-028 IPRB_t, VCRC_t, VCRD_t, their INIT/WMASK/RMASK constants and the state enum SHALL live in SH7604_PKG.
- REQ-029 Source selection SHALL be one combinational sub-module, sh7604_frt_intc_prio: 4 request bits + VCRC/VCRD in, any/vector out.

Verification
- REQ-030 IPRB[11:8]=5, FOCV=7'h40, pulse OCIB_IRQ high -> INT_REQ=1, INT_LVL=5, INT_VEC=7'h40 one CE_R later.
- REQ-031 Hold OVI_IRQ, then raise ICI_IRQ while in REQ, with FICV=7'h41 and FOVV=7'h43 -> INT_VEC changes 43h->41h; INT_ACK -> ACK for 1 CE_R, then IDLE.
- REQ-032 IPRB field=0, all sources high -> INT_REQ stays 0 for 100 cycles.
- REQ-033 In REQ, drop all sources before ACK -> INT_REQ=0 on the same CE_R; a later INT_ACK is ignored.
- REQ-034 Assert RST_N low in ACK -> INT_REQ=0 and registers read 0; byte write of 8'h0A to BASE_ADDR+0 -> IPRB reads 16'h0A00.
- REQ-035 With SH7604_FRT_INTC_STAT_EN defined, raise OCIA_IRQ -> status reads 16'h0014 once in REQ.
